// File: rtl/load_store_unit_if.sv
// Request/response and data-memory port bundle for load_store_unit.
// master: execute stage plus memory side; slave: the load/store unit.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 14
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised data memory; sub-word stores are read-modify-write.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
   parameter int unsigned ADDR_W = 14
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

   state_t            state, state_n;
   logic              we_q, uns_q, err_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, merge_q, rdata_q;
   logic              misalign, illegal;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_val, merge_val;
   logic              unused_addr_hi;

   // Address bits above the memory size wrap away.
   assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign illegal = (bus.req_size == 2'b11) || misalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (illegal)                   state_n = RESP;
               else if (!bus.req_we)          state_n = LOAD;
               else if (bus.req_size == 2'b10) state_n = WRITE;
               else                           state_n = MERGE;
            end
         end
         LOAD:    state_n = RESP;
         MERGE:   state_n = WRITE;
         WRITE:   state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Lane selection: halfwords use addr[1] only, so addr[0] is ignored when not trapping.
   always_comb begin
      lane_b    = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h    = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_val  = bus.mem_rdata;
      merge_val = bus.mem_rdata;
      case (size_q)
         2'b00: begin
            load_val = {{24{~uns_q & lane_b[7]}}, lane_b};
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_val = {{16{~uns_q & lane_h[15]}}, lane_h};
            merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: ;
      endcase
   end

   // Response data/error are written only on the way into RESP so they hold between responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  uns_q   <= bus.req_unsigned;
                  size_q  <= bus.req_size;
                  addr_q  <= bus.req_addr[ADDR_W-1:0];
                  wdata_q <= bus.req_wdata;
                  if (illegal) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            LOAD: begin
               rdata_q <= load_val;
               err_q   <= 1'b0;
            end
            MERGE: merge_q <= merge_val;
            WRITE: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.req_ready  = (state == IDLE);
      bus.resp_valid = (state == RESP);
      bus.resp_rdata = rdata_q;
      bus.resp_err   = err_q & (state == RESP);
      bus.mem_we     = (state == WRITE);
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      if ((state == LOAD) || (state == MERGE) || (state == WRITE))
         bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (state == WRITE)
         bus.mem_wdata = (size_q == 2'b10) ? wdata_q : merge_q;
   end

   // we_q is kept for debug visibility of the accepted request type.
   logic unused_we;
   assign unused_we = we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a behavioural 16 KB word memory.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_mem = 1'b1;
   logic [31:0] mem [0:4095];
   int checks = 0;
   int failures = 0;

   load_store_unit_if #(.ADDR_W(14)) bus ();
   load_store_unit #(.ADDR_W(14)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 4096; i++) mem[i] <= '0;
         mem[5] <= 32'hABCDEF01;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_resp;
      int          exp_we;
      logic [31:0] exp_wdata;
      logic [13:0] exp_maddr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] er, input logic e, input int rc,
                               input int wc, input logic [31:0] ew, input logic [13:0] ma);
      vec_t v;
      v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
      v.exp_rdata = er; v.exp_err = e; v.exp_resp = rc; v.exp_we = wc;
      v.exp_wdata = ew; v.exp_maddr = ma;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v, output int rc, output int rcnt,
                          output logic [31:0] rd, output logic er, output int wc,
                          output int wcnt, output logic [31:0] wd,
                          output logic [31:0] wa, output logic [31:0] ma1);
      @(negedge clk);
      bus.req_we = v.we; bus.req_size = v.size; bus.req_unsigned = v.uns;
      bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_valid = 1'b1;
      rc = -1; rcnt = 0; rd = 'x; er = 1'bx; wc = 0; wcnt = 0; wd = '0; wa = '0; ma1 = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.req_valid = 1'b0;
            ma1 = 32'(bus.mem_addr);
         end
         if (bus.resp_valid) begin
            rcnt++;
            if (rc < 0) begin
               rc = k; rd = bus.resp_rdata; er = bus.resp_err;
            end
         end
         if (bus.mem_we) begin
            wcnt++;
            if (wc == 0) begin
               wc = k; wd = bus.mem_wdata; wa = 32'(bus.mem_addr);
            end
         end
      end
   endtask

   initial begin
      int rc, rcnt, wc, wcnt, nacc, nresp;
      logic [31:0] rd, wd, wa, ma1;
      logic er;
      int acc[$];

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

      vecs.push_back(mk(0, 2'b10, 0, 32'h14,   0, 32'hABCDEF01, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b00, 0, 32'h17,   0, 32'hFFFFFFAB, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b00, 1, 32'h17,   0, 32'h000000AB, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b01, 0, 32'h14,   0, 32'hFFFFEF01, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b01, 1, 32'h16,   0, 32'h0000ABCD, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b00, 0, 32'h14,   0, 32'h00000001, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b01, 0, 32'h16,   0, 32'hFFFFABCD, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b10, 0, 32'h4014, 0, 32'hABCDEF01, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b11, 0, 32'h14,   0, 32'h0, 1, 1, 0, 0, 14'h0));
      vecs.push_back(mk(1, 2'b11, 0, 32'h14, 32'hFFFFFFFF, 32'h0, 1, 1, 0, 0, 14'h0));
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(mk(0, 2'b10, 0, 32'h15, 0, 32'h0, 1, 1, 0, 0, 14'h0));
      vecs.push_back(mk(0, 2'b01, 0, 32'h15, 0, 32'h0, 1, 1, 0, 0, 14'h0));
`else
      vecs.push_back(mk(0, 2'b10, 0, 32'h15, 0, 32'hABCDEF01, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(0, 2'b01, 0, 32'h15, 0, 32'hFFFFEF01, 0, 2, 0, 0, 14'h14));
`endif
      vecs.push_back(mk(1, 2'b00, 0, 32'h15, 32'h5A, 0, 0, 3, 2, 32'hABCD5A01, 14'h14));
      vecs.push_back(mk(1, 2'b01, 0, 32'h16, 32'h1234, 0, 0, 3, 2, 32'h12345A01, 14'h14));
      vecs.push_back(mk(0, 2'b10, 0, 32'h14, 0, 32'h12345A01, 0, 2, 0, 0, 14'h14));
      vecs.push_back(mk(1, 2'b10, 0, 32'h14, 32'hABCDEF01, 0, 0, 2, 1, 32'hABCDEF01, 14'h14));
      vecs.push_back(mk(1, 2'b00, 0, 32'h23, 32'hFFFFFF77, 0, 0, 3, 2, 32'h77000000, 14'h20));
      vecs.push_back(mk(0, 2'b10, 0, 32'h20, 0, 32'h77000000, 0, 2, 0, 0, 14'h20));
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(mk(1, 2'b10, 0, 32'h26, 32'hCAFEF00D, 0, 1, 1, 0, 0, 14'h0));
      vecs.push_back(mk(0, 2'b10, 0, 32'h24, 0, 32'h0, 0, 2, 0, 0, 14'h24));
`else
      vecs.push_back(mk(1, 2'b10, 0, 32'h26, 32'hCAFEF00D, 0, 0, 2, 1, 32'hCAFEF00D, 14'h24));
      vecs.push_back(mk(0, 2'b10, 0, 32'h24, 0, 32'hCAFEF00D, 0, 2, 0, 0, 14'h24));
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      init_mem = 1'b0;
      @(negedge clk);
      chk("reset_req_ready",  32'(bus.req_ready), 32'd1);
      chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
      chk("reset_resp_err",   32'(bus.resp_err), 32'd0);
      chk("reset_mem_we",     32'(bus.mem_we), 32'd0);
      chk("reset_mem_addr",   32'(bus.mem_addr), 32'd0);
      chk("reset_mem_wdata",  bus.mem_wdata, 32'd0);

      foreach (vecs[i]) begin
         chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'd1);
         run_req(vecs[i], rc, rcnt, rd, er, wc, wcnt, wd, wa, ma1);
         chk($sformatf("v%0d_resp_cycle", i), 32'(rc), 32'(vecs[i].exp_resp));
         chk($sformatf("v%0d_resp_count", i), 32'(rcnt), 32'd1);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_we_cycle", i), 32'(wc), 32'(vecs[i].exp_we));
         chk($sformatf("v%0d_we_count", i), 32'(wcnt), (vecs[i].exp_we != 0) ? 32'd1 : 32'd0);
         chk($sformatf("v%0d_maddr_c1", i), ma1, 32'(vecs[i].exp_maddr));
         if (vecs[i].exp_we != 0) begin
            chk($sformatf("v%0d_we_wdata", i), wd, vecs[i].exp_wdata);
            chk($sformatf("v%0d_we_addr", i), wa, 32'(vecs[i].exp_maddr));
         end
      end
      chk("rdata_hold", bus.resp_rdata, vecs[vecs.size()-1].exp_rdata);

      // Continuous req_valid: accepts every third cycle, four responses in twelve cycles.
      @(negedge clk);
      bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h4014; bus.req_valid = 1'b1;
      nresp = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus.req_ready) acc.push_back(k);
         if (bus.resp_valid) begin
            nresp++;
            chk($sformatf("b2b_rdata_%0d", k), bus.resp_rdata, 32'hABCDEF01);
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      nacc = acc.size();
      chk("b2b_accepts", 32'(nacc), 32'd4);
      chk("b2b_responses", 32'(nresp), 32'd4);
      foreach (acc[i]) chk($sformatf("b2b_accept_%0d", i), 32'(acc[i]), 32'(3 * i));

      // Reset while the byte store is in MERGE.
      repeat (2) @(negedge clk);
      bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_addr = 32'h14;
      bus.req_wdata = 32'h99; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("rst_merge_addr", 32'(bus.mem_addr), 32'h14);
      chk("rst_merge_we", 32'(bus.mem_we), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_async_we", 32'(bus.mem_we), 32'd0);
      chk("rst_async_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      nresp = 0; wcnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.resp_valid) nresp++;
         if (bus.mem_we) wcnt++;
      end
      chk("rst_no_resp", 32'(nresp), 32'd0);
      chk("rst_no_we", 32'(wcnt), 32'd0);
      chk("rst_ready_after", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_word5", mem[5], 32'hABCDEF01);
      run_req(mk(0, 2'b10, 0, 32'h14, 0, 0, 0, 0, 0, 0, 0), rc, rcnt, rd, er, wc, wcnt, wd, wa, ma1);
      chk("rst_readback", rd, 32'hABCDEF01);
      chk("rst_readback_cycle", 32'(rc), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Processor-side initiator for the 16 KB word-organised data memory: accepts load/store requests from the execute stage, drives the memory's `w_enable`/`addr`/`w_data` port and samples its combinational `r_data`. It handles byte/halfword loads with sign or zero extension and performs byte/halfword stores as read-modify-write, because the memory only writes whole words. It returns one response pulse per request and flags misaligned or illegal accesses.

## Interface
- `ADDR_W`, 14: memory byte-address width. The word index is `mem_addr[ADDR_W-1:2]`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address. Bits above `ADDR_W-1` are ignored, so addresses wrap modulo 16 KB.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result. 0 for stores and for errors. Held until the next response.
- `resp_err` out 1: valid with `resp_valid`. 1 = access rejected.
- `mem_we` out 1: to memory `w_enable`.
- `mem_addr` out `ADDR_W`: to memory `addr`; bits [1:0] always 0.
- `mem_wdata` out 32: to memory `w_data`.
- `mem_rdata` in 32: from memory `r_data` (combinational read).

## Operation
- **States:** IDLE, LOAD, MERGE, WRITE, RESP.
- **Accept:** in IDLE, `req_valid`=1 latches all `req_*` fields. Next state:
  - RESP with error if the request is illegal or misaligned (see Configuration).
  - LOAD for a load.
  - WRITE for a word store.
  - MERGE for a byte or halfword store.
- **LOAD:** drive `mem_addr`, capture `mem_rdata`, then extract and extend. Go to RESP.
  - Byte result comes from lane `addr[1:0]`; lane k is bits [8k+7:8k].
  - Halfword result comes from lanes {2·addr[1]+1, 2·addr[1]}.
- **MERGE:** drive `mem_addr`, capture `mem_rdata` into the merge register, and replace only the target lane(s) with `req_wdata[7:0]` or `req_wdata[15:0]`. Go to WRITE.
- **WRITE:** assert `mem_we`=1 and drive `mem_wdata`. A word store writes `req_wdata` unmodified; a sub-word store writes the merge register. Go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE. The response has no backpressure.
- **Illegal size:** `req_size`=11 always gives `resp_err`=1 with no memory access.
- **Idle drive:** outside LOAD/MERGE/WRITE, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.

## Timing
- Cycle 0 is the cycle in which `req_valid` and `req_ready` are both high.
- **Load:** LOAD in cycle 1; `resp_valid` in cycle 2.
- **Word store:** `mem_we` in cycle 1; `resp_valid` in cycle 2.
- **Sub-word store:** MERGE in cycle 1; `mem_we` in cycle 2; `resp_valid` in cycle 3.
- **Error:** `resp_valid` with `resp_err` in cycle 1; no `mem_we` at any point.
- **Back-to-back requests:** `req_ready` returns high in the cycle after RESP, so the next accept is in cycle 3, 3 or 4 respectively.
- `mem_we` is high for exactly one cycle per store and is decoded from the state register.
- **Reset values:** state IDLE; `req_ready`=1; all other outputs 0.
- **Reset mid-operation:** `rst` immediately returns the unit to IDLE and drops `mem_we`. The in-flight request is discarded with no response. A store interrupted before its WRITE edge leaves memory unchanged.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, is rejected.
  - The response is `resp_err`=1, `resp_rdata`=0, and memory is not accessed.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.
  - Only `req_size`=11 produces an error.

## Test plan
Setup for all tests: memory word 5 (byte address 0x14) is preloaded with 0xABCDEF01.

1. Load word at 0x14 → `resp_valid` in cycle 2, `resp_rdata`=0xABCDEF01, `resp_err`=0, `mem_we` never high.
2. Sub-word loads:
   - signed byte at 0x17 → 0xFFFFFFAB;
   - unsigned byte at 0x17 → 0x000000AB;
   - signed halfword at 0x14 → 0xFFFFEF01;
   - unsigned halfword at 0x16 → 0x0000ABCD.
3. Byte store of 0x5A at 0x15 → `mem_we` only in cycle 2 with `mem_addr`=0x14 and `mem_wdata`=0xABCD5A01, `resp_valid` in cycle 3. Then halfword store of 0x1234 at 0x16; a word readback returns 0x12345A01.
4. Word load at 0x15:
   - with `LSU_MISALIGN_TRAP_EN` → `resp_err`=1 in cycle 1, `resp_rdata`=0, no memory access;
   - without it → 0xABCDEF01.
   - `req_size`=11 → `resp_err`=1 in both builds.
5. Load at 0x4014 → `mem_addr`=0x0014 (wrap), result 0xABCDEF01. Keep `req_valid` high continuously → accepts occur every 3 cycles.
6. Assert `rst` during MERGE of a byte store to 0x14 → `mem_we` never asserts, no `resp_valid`, `req_ready`=1 after release, word 5 is still 0xABCDEF01.
